// File: rtl/delay_line_arb_pkg.sv
// Shared helpers and types for the delay-line arbiter: width math and the
// tag record that travels alongside each word in the external delay line.
package delay_line_arb_pkg;

    // Widest requester index supported (M up to 16).
    localparam int ID_MAX_W = 4;

    // Ceiling log2, never below 1 so a width derived from it is always legal.
    function automatic int clog2(input int value);
        int r;
        int v;
        r = 0;
        v = value - 1;
        while (v > 0) begin
            r = r + 1;
            v = v >> 1;
        end
        if (r == 0) begin
            r = 1;
        end
        return r;
    endfunction

    // Derived widths used by the block: IDW = clog2(M), CRW = clog2(CREDITS+1).
    function automatic int id_width(input int m);
        return clog2(m);
    endfunction

    function automatic int credit_width(input int credits);
        return clog2(credits + 1);
    endfunction

    // One tag stage: word-valid plus the index of the requester that issued it.
    typedef struct packed {
        logic                vld;
        logic [ID_MAX_W-1:0] id;
    } tag_t;

endpackage

// File: rtl/delay_line_arb_rr_arbiter.sv
// Combinational round-robin picker: search starts one past the last winner and
// the first eligible index wins. The pointer register lives in the parent.
module rr_arbiter
    import delay_line_arb_pkg::*;
#(
    parameter int M   = 4,
    parameter int IDW = 2
) (
    input  logic [M-1:0]   i_elig,
    input  logic [IDW-1:0] i_ptr,
    output logic [M-1:0]   o_grant,
    output logic [IDW-1:0] o_idx
);

    always_comb begin
        int   idx;
        logic found;
        o_grant = '0;
        o_idx   = '0;
        found   = 1'b0;
        idx     = 0;
        for (int k = 1; k <= M; k++) begin
            idx = (int'(i_ptr) + k) % M;
            if (!found && i_elig[idx]) begin
                found        = 1'b1;
                o_grant[idx] = 1'b1;
                o_idx        = IDW'(idx);
            end
        end
    end

endmodule

// File: rtl/delay_line_arb.sv
// Round-robin sharing of one non-stallable N-stage delay line among M requesters,
// with a tag pipeline that steers each returning word and per-requester credits.
module delay_line_arb
    import delay_line_arb_pkg::*;
#(
    parameter int DW      = 8,
    parameter int N       = 8,
    parameter int M       = 4,
    parameter int CREDITS = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [M-1:0]      req_valid,
    input  logic [M*DW-1:0]   req_data,
    output logic [M-1:0]      req_ready,
    output logic [DW-1:0]     pipe_din,
    input  logic [DW-1:0]     pipe_dout,
    output logic [M-1:0]      out_valid,
    output logic [DW-1:0]     out_data,
    input  logic [M-1:0]      credit_ret,
    output logic              busy,
    output logic              err
);

    localparam int IDW = id_width(M);
    localparam int CRW = credit_width(CREDITS);
    localparam logic [CRW-1:0] CRED_MAX = CRW'(CREDITS);
    localparam logic [IDW-1:0] PTR_INIT = IDW'(M - 1);

    logic [CRW-1:0] r_credit [M];
    logic [IDW-1:0] r_rr_ptr;
    logic           r_err;

    logic [M-1:0]   w_elig;
    logic [M-1:0]   w_grant;
    logic [IDW-1:0] w_gidx;
    logic           w_accept;

    // Handshake: requester i hands over a word in a cycle where req_valid[i] and
    // req_ready[i] are both high; ready never depends on anything but valid,
    // credit and the pointer, and is held low throughout reset.
    always_comb begin
        w_elig = '0;
        for (int i = 0; i < M; i++) begin
            w_elig[i] = rst && req_valid[i] && (r_credit[i] != '0);
        end
    end

    rr_arbiter #(
        .M   (M),
        .IDW (IDW)
    ) u_arb (
        .i_elig  (w_elig),
        .i_ptr   (r_rr_ptr),
        .o_grant (w_grant),
        .o_idx   (w_gidx)
    );

    assign w_accept  = |w_grant;
    assign req_ready = w_grant;
    assign pipe_din  = w_accept ? req_data[w_gidx*DW +: DW] : '0;
    assign out_data  = pipe_dout;
    assign err       = r_err;

    always_ff @(posedge clk) begin
        if (!rst) begin
            r_rr_ptr <= PTR_INIT;
        end else if (w_accept) begin
            r_rr_ptr <= w_gidx;
        end
    end

    // Accept and return in the same cycle cancel, so the counter holds.
    always_ff @(posedge clk) begin
        if (!rst) begin
            r_err <= 1'b0;
            for (int i = 0; i < M; i++) begin
                r_credit[i] <= CRED_MAX;
            end
        end else begin
            for (int i = 0; i < M; i++) begin
                if (w_grant[i] && !credit_ret[i]) begin
                    r_credit[i] <= r_credit[i] - CRW'(1);
                end else if (!w_grant[i] && credit_ret[i]) begin
                    if (r_credit[i] == CRED_MAX) begin
                        r_err <= 1'b1;
                    end else begin
                        r_credit[i] <= r_credit[i] + CRW'(1);
                    end
                end
            end
        end
    end

    generate
        if (N > 0) begin : g_tags
            tag_t r_tags [N];
            tag_t w_tag_in;

            always_comb begin
                w_tag_in.vld = w_accept;
                w_tag_in.id  = ID_MAX_W'(w_gidx);
            end

            // Clearing tags on reset hides the delay line's reset contents.
            always_ff @(posedge clk) begin
                if (!rst) begin
                    for (int s = 0; s < N; s++) begin
                        r_tags[s] <= '0;
                    end
                end else begin
                    r_tags[0] <= w_tag_in;
                    for (int s = 1; s < N; s++) begin
                        r_tags[s] <= r_tags[s-1];
                    end
                end
            end

            always_comb begin
                out_valid = '0;
                busy      = 1'b0;
                for (int i = 0; i < M; i++) begin
                    out_valid[i] = r_tags[N-1].vld && (r_tags[N-1].id == ID_MAX_W'(i));
                end
                for (int s = 0; s < N; s++) begin
                    busy = busy | r_tags[s].vld;
                end
            end
        end else begin : g_pass
            assign out_valid = w_grant;
            assign busy      = 1'b0;
        end
    endgenerate

endmodule

// File: tb/tb_delay_line_arb.sv
// Bench for delay_line_arb: an N=8 instance behind a modelled delay line and an
// N=0 instance on the same stimulus, both checked against a queue-based model.
module tb_delay_line_arb;

    localparam int DW      = 8;
    localparam int N       = 8;
    localparam int M       = 4;
    localparam int CREDITS = 4;
    localparam int EW      = 32 + 4 + DW;

    // ---------------- clock / reset / signals ----------------
    logic            clk;
    logic            rst;
    logic [M-1:0]    req_valid;
    logic [M*DW-1:0] req_data;
    logic [M-1:0]    credit_ret;

    logic [M-1:0]    req_ready,  req_ready0;
    logic [DW-1:0]   pipe_din,   pipe_din0;
    logic [DW-1:0]   pipe_dout,  pipe_dout0;
    logic [M-1:0]    out_valid,  out_valid0;
    logic [DW-1:0]   out_data,   out_data0;
    logic            busy,       busy0;
    logic            err,        err0;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    delay_line_arb #(.DW(DW), .N(N), .M(M), .CREDITS(CREDITS)) dut (
        .clk        (clk),
        .rst        (rst),
        .req_valid  (req_valid),
        .req_data   (req_data),
        .req_ready  (req_ready),
        .pipe_din   (pipe_din),
        .pipe_dout  (pipe_dout),
        .out_valid  (out_valid),
        .out_data   (out_data),
        .credit_ret (credit_ret),
        .busy       (busy),
        .err        (err)
    );

    delay_line_arb #(.DW(DW), .N(0), .M(M), .CREDITS(CREDITS)) dut0 (
        .clk        (clk),
        .rst        (rst),
        .req_valid  (req_valid),
        .req_data   (req_data),
        .req_ready  (req_ready0),
        .pipe_din   (pipe_din0),
        .pipe_dout  (pipe_dout0),
        .out_valid  (out_valid0),
        .out_data   (out_data0),
        .credit_ret (credit_ret),
        .busy       (busy0),
        .err        (err0)
    );

    // External delay line: N plain registers, reset to all ones.
    logic [DW-1:0] dl [N];
    always_ff @(posedge clk) begin
        if (!rst) begin
            for (int s = 0; s < N; s++) dl[s] <= '1;
        end else begin
            dl[0] <= pipe_din;
            for (int s = 1; s < N; s++) dl[s] <= dl[s-1];
        end
    end
    assign pipe_dout  = dl[N-1];
    assign pipe_dout0 = pipe_din0;

    // ---------------- reference model / scoreboard ----------------
    int            cyc;
    int            n_checks;
    int            n_fail;
    int            m_cred [M];
    int            m_ptr;
    logic          m_err;
    logic [EW-1:0] exp_q [$];

    logic [M-1:0]  obs_ready;
    logic [M-1:0]  obs_ov;
    logic [M-1:0]  obs_ov0;
    logic          obs_busy;
    logic          obs_err;

    task automatic model_reset();
        m_ptr = M - 1;
        m_err = 1'b0;
        exp_q.delete();
        for (int i = 0; i < M; i++) m_cred[i] = CREDITS;
    endtask

    // Drives one cycle of stimulus, checks every output, advances the model.
    task automatic step(input logic [M-1:0] v, input logic [M-1:0] ret, input logic r);
        logic [DW-1:0] d [M];
        logic [M-1:0]  eg;
        logic [DW-1:0] ed;
        logic [M-1:0]  ev;
        logic [DW-1:0] edat;
        logic [EW-1:0] head;
        logic          ebusy;
        int            gi;
        int            nv;
        rst        = r;
        req_valid  = v;
        credit_ret = ret;
        for (int i = 0; i < M; i++) begin
            d[i] = DW'($urandom_range(0, 255));
            req_data[i*DW +: DW] = d[i];
        end
        #1;
        gi = -1;
        if (r) begin
            for (int k = 1; k <= M; k++) begin
                int j;
                j = (m_ptr + k) % M;
                if (gi < 0 && v[j] && m_cred[j] > 0) gi = j;
            end
        end
        eg = '0;
        ed = '0;
        if (gi >= 0) begin
            eg[gi] = 1'b1;
            ed     = d[gi];
        end
        ebusy = (exp_q.size() > 0);
        ev    = '0;
        edat  = '0;
        if (exp_q.size() > 0 && exp_q[0][EW-1 -: 32] == 32'(cyc)) begin
            head = exp_q.pop_front();
            ev[int'(head[DW +: 4])] = 1'b1;
            edat = head[DW-1:0];
        end

        obs_ready = req_ready;
        obs_ov    = out_valid;
        obs_ov0   = out_valid0;
        obs_busy  = busy;
        obs_err   = err;

        n_checks++;
        if (req_ready !== eg) begin
            n_fail++;
            $display("FAIL req_ready cyc=%0d got=%b exp=%b", cyc, req_ready, eg);
        end
        n_checks++;
        if (pipe_din !== ed) begin
            n_fail++;
            $display("FAIL pipe_din cyc=%0d got=%h exp=%h", cyc, pipe_din, ed);
        end
        n_checks++;
        if (out_valid !== ev) begin
            n_fail++;
            $display("FAIL out_valid cyc=%0d got=%b exp=%b", cyc, out_valid, ev);
        end
        if (ev != '0) begin
            n_checks++;
            if (out_data !== edat) begin
                n_fail++;
                $display("FAIL out_data cyc=%0d got=%h exp=%h", cyc, out_data, edat);
            end
        end
        n_checks++;
        if (busy !== ebusy) begin
            n_fail++;
            $display("FAIL busy cyc=%0d got=%b exp=%b", cyc, busy, ebusy);
        end
        n_checks++;
        if (err !== m_err) begin
            n_fail++;
            $display("FAIL err cyc=%0d got=%b exp=%b", cyc, err, m_err);
        end
        n_checks++;
        if (req_ready0 !== eg || out_valid0 !== eg) begin
            n_fail++;
            $display("FAIL n0_grant cyc=%0d ready=%b valid=%b exp=%b", cyc, req_ready0, out_valid0, eg);
        end
        if (gi >= 0) begin
            n_checks++;
            if (out_data0 !== ed) begin
                n_fail++;
                $display("FAIL n0_data cyc=%0d got=%h exp=%h", cyc, out_data0, ed);
            end
        end
        n_checks++;
        if (busy0 !== 1'b0 || err0 !== m_err) begin
            n_fail++;
            $display("FAIL n0_flags cyc=%0d busy=%b err=%b exp_err=%b", cyc, busy0, err0, m_err);
        end

        if (!r) begin
            model_reset();
        end else begin
            if (gi >= 0) begin
                m_ptr = gi;
                exp_q.push_back({32'(cyc + N), 4'(gi), ed});
            end
            for (int i = 0; i < M; i++) begin
                nv = m_cred[i] - ((gi == i) ? 1 : 0) + (ret[i] ? 1 : 0);
                if (nv > CREDITS) begin
                    m_err = 1'b1;
                    nv    = CREDITS;
                end
                m_cred[i] = nv;
            end
        end
        @(posedge clk);
        cyc++;
        @(negedge clk);
    endtask

    task automatic idle(input int n);
        for (int k = 0; k < n; k++) step('0, '0, 1'b1);
    endtask

    // ---------------- tests ----------------
    task automatic test_reset();
        step(4'hF, '0, 1'b0);
        n_checks++;
        if (obs_ready !== '0) begin
            n_fail++;
            $display("FAIL reset_ready got=%b exp=0000", obs_ready);
        end
        step('0, '0, 1'b1);
        n_checks++;
        if (obs_ov !== '0 || obs_busy !== 1'b0 || obs_err !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_state ov=%b busy=%b err=%b exp 0/0/0", obs_ov, obs_busy, obs_err);
        end
        step(4'hF, '0, 1'b1);
        n_checks++;
        if (obs_ready !== 4'b0001) begin
            n_fail++;
            $display("FAIL reset_first_grant got=%b exp=0001", obs_ready);
        end
        idle(N + 2);
    endtask

    task automatic test_round_robin();
        int words;
        words = 0;
        step('0, '0, 1'b0);
        for (int k = 0; k < 12; k++) begin
            step(4'hF, '0, 1'b1);
            if (obs_ov != '0) words++;
            n_checks++;
            if (obs_ready !== (4'b0001 << (k % 4)) || obs_ov0 !== (4'b0001 << (k % 4))) begin
                n_fail++;
                $display("FAIL rr_order k=%0d got=%b n0=%b exp=%b", k, obs_ready, obs_ov0, 4'b0001 << (k % 4));
            end
        end
        for (int k = 0; k < 10; k++) begin
            step('0, '0, 1'b1);
            if (obs_ov != '0) words++;
        end
        n_checks++;
        if (words != 12) begin
            n_fail++;
            $display("FAIL rr_word_count got=%0d exp=12", words);
        end
        for (int k = 0; k < 3; k++) step('0, 4'hF, 1'b1);
    endtask

    task automatic test_credit_limit();
        int acc;
        step('0, '0, 1'b0);
        acc = 0;
        for (int k = 0; k < 7; k++) begin
            step(4'b0100, '0, 1'b1);
            if (obs_ready[2]) acc++;
        end
        n_checks++;
        if (acc != 4 || obs_ready !== '0) begin
            n_fail++;
            $display("FAIL credit_limit accepts=%0d last_ready=%b exp 4/0000", acc, obs_ready);
        end
        step(4'b0100, 4'b0100, 1'b1);
        acc = 0;
        for (int k = 0; k < 4; k++) begin
            step(4'b0100, '0, 1'b1);
            if (obs_ready[2]) acc++;
        end
        n_checks++;
        if (acc != 1) begin
            n_fail++;
            $display("FAIL credit_return accepts=%0d exp=1", acc);
        end
        idle(N + 2);
    endtask

    task automatic test_skip();
        step('0, '0, 1'b0);
        for (int k = 0; k < 4; k++) step(4'b0010, '0, 1'b1);
        for (int k = 0; k < 8; k++) begin
            step(4'b1011, '0, 1'b1);
            n_checks++;
            if (obs_ready !== ((k % 2 == 0) ? 4'b1000 : 4'b0001)) begin
                n_fail++;
                $display("FAIL skip_order k=%0d got=%b exp=%b", k, obs_ready,
                         (k % 2 == 0) ? 4'b1000 : 4'b0001);
            end
        end
        step(4'b1011, '0, 1'b1);
        n_checks++;
        if (obs_ready !== '0) begin
            n_fail++;
            $display("FAIL skip_exhausted got=%b exp=0000", obs_ready);
        end
        idle(N + 2);
    endtask

    task automatic test_same_cycle();
        int acc;
        step('0, '0, 1'b0);
        step(4'b0001, 4'b0001, 1'b1);
        acc = 0;
        for (int k = 0; k < 5; k++) begin
            step(4'b0001, '0, 1'b1);
            if (obs_ready[0]) acc++;
        end
        n_checks++;
        if (acc != 4 || obs_err !== 1'b0) begin
            n_fail++;
            $display("FAIL same_cycle accepts=%0d err=%b exp 4/0", acc, obs_err);
        end
        for (int k = 0; k < 4; k++) step('0, 4'b0001, 1'b1);
        step('0, '0, 1'b1);
        n_checks++;
        if (obs_err !== 1'b0) begin
            n_fail++;
            $display("FAIL err_early got=%b exp=0", obs_err);
        end
        step('0, 4'b0001, 1'b1);
        for (int k = 0; k < 4; k++) begin
            step('0, '0, 1'b1);
            n_checks++;
            if (obs_err !== 1'b1) begin
                n_fail++;
                $display("FAIL err_sticky k=%0d got=%b exp=1", k, obs_err);
            end
        end
        step('0, '0, 1'b0);
        step('0, '0, 1'b1);
        n_checks++;
        if (obs_err !== 1'b0) begin
            n_fail++;
            $display("FAIL err_clear got=%b exp=0", obs_err);
        end
    endtask

    task automatic test_reset_midflight();
        step('0, '0, 1'b0);
        for (int k = 0; k < 5; k++) step(4'hF, '0, 1'b1);
        step(4'hF, '0, 1'b0);
        for (int k = 0; k < N + 2; k++) begin
            step('0, '0, 1'b1);
            n_checks++;
            if (obs_ov !== '0 || obs_busy !== 1'b0) begin
                n_fail++;
                $display("FAIL midflight_drop k=%0d ov=%b busy=%b exp 0000/0", k, obs_ov, obs_busy);
            end
        end
        step(4'hF, '0, 1'b1);
        n_checks++;
        if (obs_ready !== 4'b0001) begin
            n_fail++;
            $display("FAIL midflight_first got=%b exp=0001", obs_ready);
        end
        idle(N + 2);
    endtask

    task automatic test_random();
        logic [M-1:0] v;
        logic [M-1:0] ret;
        step('0, '0, 1'b0);
        for (int k = 0; k < 400; k++) begin
            v   = M'($urandom_range(0, (1 << M) - 1));
            ret = '0;
            for (int i = 0; i < M; i++) begin
                if (m_cred[i] < CREDITS && $urandom_range(0, 2) == 0) ret[i] = 1'b1;
            end
            step(v, ret, 1'b1);
        end
        idle(N + 2);
    endtask

    initial begin
        n_checks   = 0;
        n_fail     = 0;
        cyc        = 0;
        rst        = 1'b0;
        req_valid  = '0;
        req_data   = '0;
        credit_ret = '0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        model_reset();

        test_reset();
        test_round_robin();
        test_credit_limit();
        test_skip();
        test_same_cycle();
        test_reset_midflight();
        test_random();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
